riscv_lsu: RTL and testbench
============================

// Module: riscv_lsu
// PURPOSE
//  Parametrised load/store unit between the multi-cycle core control unit and the data RAM port.
//  Handles byte/half/word (and double when XLEN=64) accesses with byte enables, lane steering
//  and sign/zero extension, and waits on d_data_valid with a bounded timeout.
//  Flags misaligned and timed-out accesses as errors instead of silently issuing them.
// PARAMETERS
//  XLEN     32  data width, 32 or 64; byte lanes NB = XLEN/8, lane-index bits LB = log2(NB)
//  ADDR_W   32  byte-address width
//  TIMEOUT  16  maximum ACCESS cycles waiting for d_data_valid; 0 = wait forever
// PORTS
//  clk            in   1        clock, all state updates on rising edge
//  reset          in   1        asynchronous, active-high reset
//  req_valid      in   1        request present
//  req_ready      out  1        LSU can accept a request (high only in IDLE)
//  req_we         in   1        1 = store, 0 = load
//  req_size       in   2        00 byte, 01 half, 10 word, 11 double (legal only if XLEN=64)
//  req_unsigned   in   1        load zero-extends when 1, sign-extends when 0
//  req_addr       in   ADDR_W   byte address
//  req_wdata      in   XLEN     store data, right-justified
//  rsp_valid      out  1        one-cycle response strobe
//  rsp_err        out  1        valid with rsp_valid: misaligned, illegal size or timeout
//  rsp_rdata      out  XLEN     extended load data; 0 for stores and errors
//  d_req          out  1        memory access in progress
//  d_address      out  ADDR_W   lane-aligned address: req_addr with low LB bits cleared
//  d_data_write   out  XLEN     store data shifted to its lane(s)
//  d_byte_en      out  NB       active byte lanes (loads and stores)
//  d_write_enable out  1        store strobe, only while d_req
//  d_data_read    in   XLEN     read word from memory
//  d_data_valid   in   1        memory completes the current access this cycle
// BEHAVIOUR
//  States IDLE, ACCESS, RESP. Reset (async) -> IDLE; outputs during/after reset:
//   req_ready=1, all other outputs 0. Reset mid-ACCESS drops d_req/d_write_enable immediately.
//  IDLE: req_ready=1. Accept when req_valid && req_ready; capture all req_* fields.
//   Misaligned (half: addr[0]!=0; word: addr[1:0]!=0; double: addr[2:0]!=0) or size 11 with
//   XLEN=32 -> RESP with err=1, no memory access issued. Otherwise -> ACCESS, cycle counter=0.
//  ACCESS: d_req=1, d_write_enable=req_we, d_address/d_byte_en/d_data_write stable for the
//   whole state. byte_en = ((1<<(1<<size))-1) << addr[LB-1:0]; d_data_write = wdata << 8*addr[LB-1:0].
//   d_data_valid=1 -> load result = (d_data_read >> 8*addr[LB-1:0]) truncated to size and extended,
//   registered into rsp_rdata; -> RESP err=0.
//   Else counter++; when TIMEOUT!=0 and counter reaches TIMEOUT-1 with no valid -> RESP err=1.
//  RESP: rsp_valid=1 for exactly one cycle (no backpressure), then IDLE. rsp_rdata/rsp_err hold
//   until the next response; req_ready=0 in ACCESS and RESP.
//  Latency: accept at edge N; ACCESS cycle N+1; valid in that cycle -> rsp_valid in cycle N+2.
//   Error on accept -> rsp_valid in cycle N+1. d_data_valid outside ACCESS is ignored.
//  Same-cycle valid and timeout: valid wins (err=0).
// TESTING
//  LB signed, mem word@0x100=0x8070_6050, addr 0x103 -> d_address 0x100, byte_en 1000,
//   rsp_rdata 0xFFFF_FF80, err=0, rsp_valid two cycles after accept.
//  LHU addr 0x102, same word -> byte_en 1100, rsp_rdata 0x0000_8070.
//  SB addr 0x101 wdata 0x0000_00AB, memory valid after 3 cycles -> d_data_write 0x0000_AB00,
//   byte_en 0010, d_write_enable held 3 cycles, rsp_rdata 0.
//  LW addr 0x102 -> d_req never asserted, rsp_valid=1 err=1 one cycle after accept.
//  TIMEOUT=4, d_data_valid held 0 -> d_req high exactly 4 cycles, then rsp_err=1; req_ready back to 1.
//  Reset asserted during store ACCESS -> d_write_enable/d_req 0 same cycle, no rsp_valid, IDLE.

Source files
------------

// File: rtl/riscv_lsu.sv
// -----------------------------------------------------------------------------
// riscv_lsu - load/store unit between the core control unit and the data RAM.
//
// Takes one request at a time from the core. It steers byte lanes and
// generates byte enables for stores. For loads it applies sign or zero
// extension. It waits for the memory with a bounded timeout. A misaligned
// request, an illegal size or a timed-out access returns an error response.
// A request that is misaligned or has an illegal size never reaches memory.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   req_valid/ready     request handshake (ready only in IDLE)
//   req_we, req_size,   request kind, size (00 b / 01 h / 10 w / 11 d),
//   req_unsigned,       zero-extend flag, byte address and
//   req_addr, req_wdata right-justified store data
//   rsp_valid/err/rdata one-cycle response strobe, error flag, load data
//   d_req, d_address,   memory access strobe, lane-aligned address,
//   d_data_write,       lane-steered store data, byte enables and
//   d_byte_en,          store strobe
//   d_write_enable
//   d_data_read/valid   memory read data and completion strobe
// -----------------------------------------------------------------------------
module riscv_lsu #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              d_req,
  output logic [ADDR_W-1:0] d_address,
  output logic [XLEN-1:0]   d_data_write,
  output logic [XLEN/8-1:0] d_byte_en,
  output logic              d_write_enable,
  input  logic [XLEN-1:0]   d_data_read,
  input  logic              d_data_valid
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned LB    = $clog2(NB);
  localparam int unsigned CNT_W = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [LB-1:0]     lane_q;
  logic              req_bad;
  logic              timed_out;
  logic [LB+2:0]     rd_shift;

  // Returns 1 when the access cannot be issued: address not size-aligned,
  // or a double access on a 32-bit datapath.
  function automatic logic access_illegal(input logic [1:0] size, input logic [2:0] alow);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = alow[0];
      2'b10:   bad = |alow[1:0];
      2'b11:   bad = (XLEN == 32'd32) ? 1'b1 : (|alow[2:0]);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte-enable pattern: (2^size) contiguous lanes starting at the lane offset.
  function automatic logic [NB-1:0] lane_mask(input logic [1:0] size, input logic [LB-1:0] lane);
    logic [NB-1:0] base;
    case (size)
      2'b00:   base = NB'(1'b1);
      2'b01:   base = NB'(2'b11);
      2'b10:   base = NB'(4'hF);
      2'b11:   base = NB'(8'hFF);
      default: base = NB'(1'b0);
    endcase
    return base << lane;
  endfunction

  // Truncates right-justified read data to the access size and extends it.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] raw,
                                                  input logic [1:0] size,
                                                  input logic uns);
    logic [XLEN-1:0] keep;
    logic            sign;
    case (size)
      2'b00:   begin keep = XLEN'(8'hFF);         sign = raw[7];  end
      2'b01:   begin keep = XLEN'(16'hFFFF);      sign = raw[15]; end
      2'b10:   begin keep = XLEN'(32'hFFFF_FFFF); sign = raw[31]; end
      default: begin keep = {XLEN{1'b1}};         sign = 1'b0;    end
    endcase
    return (raw & keep) | ((sign && !uns) ? ~keep : {XLEN{1'b0}});
  endfunction

  // Request legality and timeout detection.
  always_comb begin
    req_bad   = access_illegal(req_size, req_addr[2:0]);
    // Counter has already spent TIMEOUT-1 cycles, so this is the last ACCESS cycle.
    timed_out = (TIMEOUT != 32'd0) && (cnt == CNT_W'(TIMEOUT - 32'd1));
    rd_shift  = {lane_q, 3'b000};
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a valid memory completion wins over a same-cycle timeout.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          next_state = req_bad ? RESP : ACCESS;
        end else begin
          next_state = IDLE;
        end
      end
      ACCESS: begin
        if (d_data_valid || timed_out) begin
          next_state = RESP;
        end else begin
          next_state = ACCESS;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake and memory strobes decoded from the state register, so reset
  // drops d_req / d_write_enable asynchronously.
  always_comb begin
    req_ready      = (state == IDLE);
    rsp_valid      = (state == RESP);
    d_req          = (state == ACCESS);
    d_write_enable = (state == ACCESS) && we_q;
  end

  // Request capture, memory-side registers, wait counter and response data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      lane_q       <= {LB{1'b0}};
      cnt          <= {CNT_W{1'b0}};
      d_address    <= {ADDR_W{1'b0}};
      d_byte_en    <= {NB{1'b0}};
      d_data_write <= {XLEN{1'b0}};
      rsp_err      <= 1'b0;
      rsp_rdata    <= {XLEN{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cnt <= {CNT_W{1'b0}};
            if (req_bad) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= {XLEN{1'b0}};
            end else begin
              we_q         <= req_we;
              size_q       <= req_size;
              uns_q        <= req_unsigned;
              lane_q       <= req_addr[LB-1:0];
              d_address    <= {req_addr[ADDR_W-1:LB], {LB{1'b0}}};
              d_byte_en    <= lane_mask(req_size, req_addr[LB-1:0]);
              d_data_write <= req_wdata << {req_addr[LB-1:0], 3'b000};
            end
          end
        end
        ACCESS: begin
          if (d_data_valid || timed_out) begin
            // Clear the memory-side bus so it reads as idle outside ACCESS.
            d_address    <= {ADDR_W{1'b0}};
            d_byte_en    <= {NB{1'b0}};
            d_data_write <= {XLEN{1'b0}};
            rsp_err      <= !d_data_valid;
            if (d_data_valid && !we_q) begin
              rsp_rdata <= load_extend(d_data_read >> rd_shift, size_q, uns_q);
            end else begin
              rsp_rdata <= {XLEN{1'b0}};
            end
          end else if (TIMEOUT != 32'd0) begin
            cnt <= cnt + CNT_W'(1'b1);
          end else begin
            cnt <= cnt;
          end
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
module tb_riscv_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        d_req;
  logic [31:0] d_address;
  logic [31:0] d_data_write;
  logic [3:0]  d_byte_en;
  logic        d_write_enable;
  logic [31:0] d_data_read;
  logic        d_data_valid;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [7:0]  nreq;   // expected ACCESS cycles == response latency after accept edge
  } exp_t;

  exp_t sb[$];

  riscv_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .d_req(d_req), .d_address(d_address), .d_data_write(d_data_write),
    .d_byte_en(d_byte_en), .d_write_enable(d_write_enable),
    .d_data_read(d_data_read), .d_data_valid(d_data_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h8070_6050;
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction

  // dcyc: ACCESS cycle (1-based) on which memory answers; 0 = never.
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input int dcyc);
    exp_t        e;
    int          nbytes;
    int          lane;
    logic        bad;
    logic [31:0] word;
    logic [31:0] ld;
    int          dcount;
    bit          seen;
    int          lat;
    nbytes = 1 << size;
    lane   = int'(addr[1:0]);
    bad    = (size == 2'd3) || ((addr % nbytes) != 0);
    word   = mem_word({addr[31:2], 2'b00});
    e      = '0;
    e.addr = {addr[31:2], 2'b00};
    e.we   = we;
    ld     = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (i >= lane) e.wdata[8*i +: 8] = wdata[8*(i-lane) +: 8];
    end
    for (int i = 0; i < nbytes && !bad; i++) begin
      e.be[lane+i]  = 1'b1;
      ld[8*i +: 8]  = word[8*(lane+i) +: 8];
    end
    if (!uns && nbytes < 4 && ld[8*nbytes-1]) begin
      for (int i = nbytes; i < 4; i++) ld[8*i +: 8] = 8'hFF;
    end
    if (bad) begin
      e.err = 1'b1; e.rdata = 32'd0; e.nreq = 8'd0;
    end else if (dcyc == 0 || dcyc > TO) begin
      e.err = 1'b1; e.rdata = 32'd0; e.nreq = 8'(TO);
    end else begin
      e.err = 1'b0; e.rdata = we ? 32'd0 : ld; e.nreq = 8'(dcyc);
    end
    sb.push_back(e);

    @(negedge clk);
    check("ready_idle", 64'(req_ready), 64'd1);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;

    seen = 1'b0; dcount = 0; lat = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        lat  = k;
        d_data_valid = 1'b0;
        if (sb.size() == 0) begin
          check("sb_empty", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_err", 64'(rsp_err), 64'(e.err));
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          check("latency", 64'(lat), 64'(e.nreq));
          check("dreq_cycles", 64'(dcount), 64'(e.nreq));
        end
      end else if (d_req) begin
        dcount++;
        check("d_address", 64'(d_address), 64'(sb[0].addr));
        check("d_byte_en", 64'(d_byte_en), 64'(sb[0].be));
        check("d_data_write", 64'(d_data_write), 64'(sb[0].wdata));
        check("d_we", 64'(d_write_enable), 64'(sb[0].we));
        d_data_valid = (dcount == dcyc);
        d_data_read  = (dcount == dcyc) ? mem_word(d_address) : 32'hDEAD_BEEF;
      end else begin
        d_data_valid = 1'b0;
      end
    end
    if (!seen) begin
      check("rsp_wait", 64'd0, 64'd1);
      if (sb.size() != 0) void'(sb.pop_front());
      d_data_valid = 1'b0;
    end
    @(negedge clk);
    check("rsp_one_cycle", 64'(rsp_valid), 64'd0);
    check("ready_after", 64'(req_ready), 64'd1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; d_data_read = 32'd0; d_data_valid = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_d_req", 64'(d_req), 64'd0);
    check("rst_d_we", 64'(d_write_enable), 64'd0);
    check("rst_d_be", 64'(d_byte_en), 64'd0);
    reset = 1'b0;

    // Directed cases.
    run_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 1);        // LB  -> FFFFFF80
    run_req(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 1);        // LHU -> 00008070
    run_req(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 2);        // LH  -> FFFF8070
    run_req(1'b1, 2'd0, 1'b0, 32'h101, 32'h0000_00AB, 3); // SB, three cycles
    run_req(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 1);        // LW misaligned
    run_req(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 1);        // double on 32-bit
    run_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0);        // timeout
    run_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, TO);       // valid on last cycle wins
    run_req(1'b1, 2'd2, 1'b0, 32'h108, 32'h1234_5678, 1); // SW
    run_req(1'b1, 2'd1, 1'b0, 32'h10E, 32'hCAFE_BEEF, 2); // SH upper half

    // d_data_valid outside ACCESS is ignored.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d_data_valid = 1'b1;
      d_data_read  = 32'h1111_1111;
      check("idle_valid_rsp", 64'(rsp_valid), 64'd0);
      check("idle_valid_dreq", 64'(d_req), 64'd0);
    end
    @(negedge clk);
    d_data_valid = 1'b0;
    check("idle_valid_rsp_end", 64'(rsp_valid), 64'd0);

    // Reset in the middle of a store access.
    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h104; req_wdata = 32'h55;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("mid_dreq", 64'(d_req), 64'd1);
    check("mid_dwe", 64'(d_write_enable), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_dreq", 64'(d_req), 64'd0);
    check("rst_mid_dwe", 64'(d_write_enable), 64'd0);
    check("rst_mid_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_mid_no_rsp", 64'(rsp_valid), 64'd0);
      check("rst_mid_idle", 64'(d_req), 64'd0);
    end

    // Random traffic.
    for (int n = 0; n < 30; n++) begin
      run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              32'h100 + 32'($urandom_range(0, 255)), 32'($urandom), int'($urandom_range(0, 5)));
    end

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
